// File: rtl/cpu_uart_rx.sv
// 8N1 UART receiver with a two-flop input synchronizer, a receive FIFO,
// registered RTS flow control and sticky framing/overrun error flags.
module cpu_uart_rx #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 1_000_000,
    parameter int FIFO_DEPTH = 16,
    parameter int RTS_MARGIN = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uart_rxd,
    output logic                          uart_rts,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          framing_error,
    output logic                          overrun_error,
    input  logic                          clear_errors
);
    localparam int BIT_PERIOD = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W      = $clog2(BIT_PERIOD + 1);
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int CW         = AW + 1;

    localparam logic [CNT_W-1:0] FULL_BIT  = CNT_W'(BIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(BIT_PERIOD / 2 - 1);
    localparam logic [CW-1:0]    DEPTH_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]    RTS_CNT   = CW'(RTS_MARGIN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Synchronizer flops idle high so reset never looks like a start bit.
    logic [1:0] sync_reg;
    logic       rxd_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], uart_rxd};
        end
    end

    assign rxd_s = sync_reg[1];

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] baud_reg, baud_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             push_req;
    logic             stop_bad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        push_req   = 1'b0;
        stop_bad   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!rxd_s) begin
                    state_next = S_START;
                    baud_next  = '0;
                    bit_next   = '0;
                end
            end
            S_START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (baud_reg == HALF_BIT) begin
                    baud_next  = '0;
                    state_next = rxd_s ? S_IDLE : S_DATA;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_reg == FULL_BIT) begin
                    baud_next  = '0;
                    shift_next = {rxd_s, shift_reg[7:1]};
                    bit_next   = bit_reg + 1'b1;
                    if (bit_reg == 3'd7) begin
                        state_next = S_STOP;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            S_STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is seen.
                if (baud_reg == FULL_BIT) begin
                    baud_next  = '0;
                    state_next = S_IDLE;
                    if (rxd_s) begin
                        push_req = 1'b1;
                    end else begin
                        stop_bad = 1'b1;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          overrun_set;

    assign full        = (count_reg == DEPTH_CNT);
    assign pop         = rx_ready && (count_reg != '0);
    assign push_ok     = push_req && (!full || pop);
    assign overrun_set = push_req && full && !pop;

    // Storage is written only on an accepted push, so the head entry is stable
    // until it is popped or the FIFO goes from empty to non-empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= shift_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    logic rts_reg;
    logic framing_reg;
    logic overrun_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rts_reg     <= 1'b1;
            framing_reg <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            rts_reg <= ((DEPTH_CNT - count_reg) <= RTS_CNT);
            // A new error in the same cycle as a clear request wins.
            if (stop_bad) begin
                framing_reg <= 1'b1;
            end else if (clear_errors) begin
                framing_reg <= 1'b0;
            end
            if (overrun_set) begin
                overrun_reg <= 1'b1;
            end else if (clear_errors) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign rx_data       = mem[rd_ptr_reg];
    assign rx_valid      = (count_reg != '0);
    assign rx_count      = count_reg;
    assign uart_rts      = rts_reg;
    assign framing_error = framing_reg;
    assign overrun_error = overrun_reg;

endmodule

// File: doc/cpu_uart_rx.md
CPU_UART_RX -- requirements
Module: cpu_uart_rx

Interface
REQ-001 Parameter CLOCK_FREQ, default 100_000_000, clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 1_000_000, serial bit rate; BIT_PERIOD = CLOCK_FREQ / BAUD_RATE cycles (integer division, 100 at defaults).
REQ-003 Parameter FIFO_DEPTH, default 16, receive FIFO entries, power of two, 4..256.
REQ-004 Parameter RTS_MARGIN, default 4, free entries at or below which uart_rts is raised.
REQ-005 Port clk, input, 1, single clock for all logic.
REQ-006 Port reset, input, 1, asynchronous, active-high; clears all state.
REQ-007 Port uart_rxd, input, 1, serial line, asynchronous to clk, idle high.
REQ-008 Port uart_rts, output, 1, flow control; 1 means the remote sender must stop.
REQ-009 Port rx_data, output, 8, byte at FIFO head; valid only while rx_valid=1.
REQ-010 Port rx_valid, output, 1, FIFO not empty.
REQ-011 Port rx_ready, input, 1, consumer pop; a byte is popped on each cycle with rx_valid=1 and rx_ready=1.
REQ-012 Port rx_count, output, $clog2(FIFO_DEPTH)+1, FIFO occupancy.
REQ-013 Port framing_error, output, 1, sticky; stop bit sampled low.
REQ-014 Port overrun_error, output, 1, sticky; byte received while FIFO full and no pop.
REQ-015 Port clear_errors, input, 1, single-cycle pulse clearing both sticky flags.

Function
REQ-016 uart_rxd shall pass through a two-flop synchronizer; all logic uses only the synchronized value rxd_s.
REQ-017 The FSM shall have states S_IDLE, S_START, S_DATA, S_STOP; any other encoding shall return to S_IDLE.
REQ-018 S_IDLE: on rxd_s=0, go to S_START and clear the baud counter and the bit counter.
REQ-019 S_START: when the baud counter reaches BIT_PERIOD/2-1, sample rxd_s; if 0, go to S_DATA with the counter cleared; if 1 (glitch), return to S_IDLE with no flag change.
REQ-020 S_DATA: every BIT_PERIOD cycles, sample rxd_s into the shift register LSB first; after the 8th sample, go to S_STOP.
REQ-021 S_STOP: after BIT_PERIOD cycles, sample rxd_s and return to S_IDLE on that same cycle (mid stop bit, so the next start edge is caught).
REQ-022 Stop sample 1: push the byte into the FIFO on that cycle; rx_valid and rx_count update on the next cycle.
REQ-023 Stop sample 0: discard the byte, set framing_error, and do not push.
REQ-024 Push while rx_count=FIFO_DEPTH and no pop that cycle: drop the byte, set overrun_error, FIFO contents unchanged.
REQ-025 Push while full with a simultaneous pop: accept the push; rx_count stays FIFO_DEPTH; no overrun.
REQ-026 Push and pop on the same cycle at any other occupancy: rx_count is unchanged.
REQ-027 Pop while empty shall be ignored.
REQ-028 FIFO pointers wrap modulo FIFO_DEPTH; bytes pop in arrival order.
REQ-029 rx_data shall be the head entry combinationally from storage and shall change only after a pop or a push into an empty FIFO.
REQ-030 uart_rts is registered: 1 when FIFO_DEPTH - rx_count <= RTS_MARGIN, otherwise 0; it follows a rx_count change by one cycle.
REQ-031 clear_errors clears both flags on the next edge; if an error is set on the same cycle, set wins.

Reset
REQ-032 While reset=1: FSM in S_IDLE, counters and pointers 0, synchronizer flops 1, rx_valid=0, rx_count=0, both flags 0, uart_rts=1.
REQ-033 On the first edge after reset release, uart_rts shall go to 0 (empty FIFO).
REQ-034 Reset mid-frame shall abort the frame with no push and no flag change; reception resumes on the next start edge after release.

Verification
REQ-035 Send 0xA5, 8N1 at 100 cycles/bit, rx_ready=0 -> rx_valid=1, rx_data=0xA5, rx_count=1, flags 0.
REQ-036 Hold rxd low for 30 cycles, then high -> no push, flags 0, FSM back in S_IDLE.
REQ-037 Send 0x3C with stop bit low -> no push, framing_error=1; pulse clear_errors -> 0 next cycle.
REQ-038 Send 17 bytes 0x00..0x10 with rx_ready=0 -> uart_rts=1 once rx_count=12; rx_count=16; overrun_error=1; pops return 0x00..0x0F.
REQ-039 Full FIFO, 17th byte's push cycle with rx_ready=1 -> 0x00 popped, new byte accepted, rx_count=16, overrun_error=0.
REQ-040 Assert reset during bit 4 of a frame, release, send 0x5A -> only 0x5A is received, rx_count=1.
